// File: rtl/jt49_interp_if.sv
// Sample stream bundle for jt49_interp: low-rate input handshake plus the
// interpolated output, its strobe and the sticky underrun flag.
interface jt49_interp_if #(
  parameter int dw = 8
);
  logic signed [dw-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [dw-1:0] dout;
  logic                 dout_valid;
  logic                 underrun;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  dout,
    input  dout_valid,
    input  underrun
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output dout,
    output dout_valid,
    output underrun
  );
endinterface

// File: rtl/jt49_interp.sv
// Two-stage CIC interpolator by R = 2**depth with a one-entry input holding register.
// Build option: JT49_INTERP_UNDERRUN_ZERO_EN selects zero (defined) or repeat-last (undefined) on underrun.
module jt49_interp #(
  parameter int dw    = 8,
  parameter int depth = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  jt49_interp_if.slave bus
);

  localparam int unsigned W = dw + 2 * depth + 2;

  logic signed [dw-1:0] hold;
  logic                 hold_full;
  logic [depth-1:0]     phase;
  logic signed [W-1:0]  x_d;
  logic signed [W-1:0]  c1_d;
  logic signed [W-1:0]  i1;
  logic signed [W-1:0]  i2;
  logic signed [dw-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 underrun_q;

  logic                 slot;
  logic                 take;
  logic                 accept;
  logic signed [W-1:0]  x;
  logic signed [W-1:0]  c1;
  logic signed [W-1:0]  c2;
  logic signed [W-1:0]  u;

  assign bus.din_ready  = !hold_full;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.underrun   = underrun_q;

  // Slot decode, underrun substitution and comb section at the input rate
  always_comb begin
    slot   = 1'b0;
    take   = 1'b0;
    accept = 1'b0;
    x      = '0;
    c1     = '0;
    c2     = '0;
    u      = '0;

    slot   = cen && (phase == '0);
    take   = slot && hold_full;
    accept = bus.din_valid && !hold_full;

`ifdef JT49_INTERP_UNDERRUN_ZERO_EN
    x = '0;
`else
    x = x_d;
`endif
    if (take) begin
      x = W'(hold);
    end

    c1 = x - x_d;
    c2 = c1 - c1_d;
    u  = slot ? c2 : '0;
  end

  // Input holding register; a consume slot and an accept never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= bus.din;
        hold_full <= 1'b1;
      end else if (take) begin
        hold_full <= 1'b0;
      end
      if (slot && !hold_full) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // Phase counter, comb delays, integrators and scaled output at the cen rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      x_d          <= '0;
      c1_d         <= '0;
      i1           <= '0;
      i2           <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= cen;
      if (cen) begin
        phase  <= phase + depth'(1);
        i1     <= i1 + u;
        i2     <= i2 + i1;
        dout_q <= dw'(i2 >>> depth);
        if (slot) begin
          x_d  <= x;
          c1_d <= c1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt49_interp.sv
// Directed bench for jt49_interp (dw = 8, depth = 3): table-driven step response
// plus hand-written underrun, freeze, reset, handshake and full-scale sequences.
module tb_jt49_interp;

  logic clk;
  logic rst_n;
  logic cen;
  int   total;
  int   bad;

  jt49_interp_if #(.dw(8)) bus ();

  jt49_interp #(.dw(8), .depth(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              c;
    logic              dv;
    logic signed [7:0] d;
    logic signed [7:0] e_dout;
    logic              e_vld;
    logic              e_rdy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge
  task automatic tick(input logic c, input logic v, input logic signed [7:0] d);
    cen           = c;
    bus.din_valid = v;
    bus.din       = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    rst_n         = 1'b0;
    cen           = 1'b1;
    bus.din_valid = 1'b1;
    #1;
    chk({nm, "_dout"}, int'(bus.dout), 0);
    chk({nm, "_vld"}, int'(bus.dout_valid), 0);
    chk({nm, "_rdy"}, int'(bus.din_ready), 1);
    chk({nm, "_ur"}, int'(bus.underrun), 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_vld_in_rst"}, int'(bus.dout_valid), 0);
    rst_n         = 1'b1;
    cen           = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    chk({nm, "_rdy_after"}, int'(bus.din_ready), 1);
    @(negedge clk);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].c, tbl[i].dv, tbl[i].d);
      chk($sformatf("%s_dout_%0d", nm, i), int'(bus.dout), int'(tbl[i].e_dout));
      chk($sformatf("%s_vld_%0d", nm, i), int'(bus.dout_valid), int'(tbl[i].e_vld));
      chk($sformatf("%s_rdy_%0d", nm, i), int'(bus.din_ready), int'(tbl[i].e_rdy));
      chk($sformatf("%s_ur_%0d", nm, i), int'(bus.underrun), 0);
    end
  endtask

  initial begin
    logic signed [7:0] d;
    int                e;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    cen           = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;

    // Row 0 loads 64 with cen low; rows 1..12 are cen cycles, consume slots at 1 and 9
    tbl[0]  = '{1'b0, 1'b1, 8'sd64, 8'sd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'sd64, 8'sd0,  1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'sd64, 8'sd0,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'sd64, 8'sd8,  1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'sd64, 8'sd16, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'sd64, 8'sd24, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'sd64, 8'sd32, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'sd64, 8'sd40, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'sd64, 8'sd48, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'sd64, 8'sd56, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'sd64, 8'sd64, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'sd64, 8'sd64, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'sd64, 8'sd64, 1'b1, 1'b0};

    @(negedge clk);
    do_reset("rst0");
    run_table("step");

    // Input stops after the cycle-17 slot, so the cycle-25 slot underruns; input returns at 26
    for (int n = 13; n <= 42; n++) begin
      tick(1'b1, (n >= 26), 8'sd64);
`ifdef JT49_INTERP_UNDERRUN_ZERO_EN
      e = (n <= 26) ? 64 : (n <= 34) ? 64 - 8 * (n - 26) : (n <= 42) ? 8 * (n - 34) : 64;
`else
      e = 64;
`endif
      chk($sformatf("ur_dout_%0d", n), int'(bus.dout), e);
      chk($sformatf("ur_flag_%0d", n), int'(bus.underrun), (n >= 25) ? 1 : 0);
    end

    // Keep running with a new level, then reset in the middle of the move
    for (int n = 43; n <= 54; n++) tick(1'b1, 1'b1, -8'sd64);
    chk("ur_sticky", int'(bus.underrun), 1);
    do_reset("rst_mid");
    run_table("step2");

    // Freeze with cen low for 20 clocks partway up the ramp
    do_reset("rst1");
    tick(1'b0, 1'b1, 8'sd64);
    for (int n = 1; n <= 5; n++) begin
      tick(1'b1, 1'b1, 8'sd64);
      chk($sformatf("frz_pre_%0d", n), int'(bus.dout), (n < 2) ? 0 : 8 * (n - 2));
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1, 8'sd64);
      chk($sformatf("frz_dout_%0d", k), int'(bus.dout), 24);
      chk($sformatf("frz_vld_%0d", k), int'(bus.dout_valid), 0);
    end
    for (int n = 6; n <= 10; n++) begin
      tick(1'b1, 1'b1, 8'sd64);
      chk($sformatf("frz_post_%0d", n), int'(bus.dout), 8 * (n - 2));
    end

    // A held 80 must survive -80 presented while the register is full
    do_reset("rst2");
    tick(1'b0, 1'b1, 8'sd80);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, -8'sd80);
      chk($sformatf("hold_rdy_%0d", k), int'(bus.din_ready), 0);
    end
    tick(1'b1, 1'b1, -8'sd80);
    chk("hold_consume_rdy", int'(bus.din_ready), 1);
    for (int m = 1; m <= 17; m++) begin
      tick(1'b1, 1'b1, -8'sd80);
      if (m == 1) chk("hold_accept_rdy", int'(bus.din_ready), 0);
      if (m == 2) chk("hold_dout_2", int'(bus.dout), 10);
      if (m == 3) chk("hold_dout_3", int'(bus.dout), 20);
      if (m == 10) chk("hold_dout_10", int'(bus.dout), 60);
      if (m == 17) chk("hold_dout_17", int'(bus.dout), -80);
    end

    // Full-scale alternation: -128, 127, -128 on successive slots
    do_reset("rst3");
    tick(1'b0, 1'b1, -8'sd128);
    for (int n = 1; n <= 26; n++) begin
      d = (n < 2) ? -8'sd128 : ((((n - 2) / 8) % 2) == 0 ? 8'sd127 : -8'sd128);
      tick(1'b1, 1'b1, d);
      if (n == 10) chk("fs_10", int'(bus.dout), -128);
      if (n == 11) chk("fs_11", int'(bus.dout), -97);
      if (n == 14) chk("fs_14", int'(bus.dout), -1);
      if (n == 18) chk("fs_18", int'(bus.dout), 127);
      if (n == 22) chk("fs_22", int'(bus.dout), -1);
      if (n == 26) chk("fs_26", int'(bus.dout), -128);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
